// File: rtl/core_mem_arb_pkg.sv
// Shared types and constants for the core memory arbiter: source encodings,
// tag-FIFO entry, and the packed downstream request/response payloads.
package core_mem_arb_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] FETCH_ORDER = 2'b10;
  localparam logic [3:0] FETCH_MASK  = 4'hF;

  // wide enough for an outstanding count of up to 16
  localparam int CNT_W = 5;

  typedef struct packed {
    logic src;
    logic drop;
  } tag_t;

  typedef struct packed {
    logic        src;
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [13:0] tid;
    logic [1:0]  mmumod;
    logic [31:0] pdt;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_req_t;

  typedef struct packed {
    logic        pagefault;
    logic [27:0] mmu_flags;
    logic [63:0] data;
  } mem_rsp_t;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface core_mem_arbiter_if;

  logic        iINST_REQ;
  logic        oINST_LOCK;
  logic [1:0]  iINST_MMUMOD;
  logic [31:0] iINST_PDT;
  logic [31:0] iINST_ADDR;
  logic        iINST_DISCARD;
  logic        oINST_VALID;
  logic        oINST_PAGEFAULT;
  logic [63:0] oINST_DATA;
  logic [27:0] oINST_MMU_FLAGS;

  logic        iDATA_REQ;
  logic        oDATA_LOCK;
  logic [1:0]  iDATA_ORDER;
  logic [3:0]  iDATA_MASK;
  logic        iDATA_RW;
  logic [13:0] iDATA_TID;
  logic [1:0]  iDATA_MMUMOD;
  logic [31:0] iDATA_PDT;
  logic [31:0] iDATA_ADDR;
  logic [31:0] iDATA_DATA;
  logic        oDATA_VALID;
  logic        oDATA_PAGEFAULT;
  logic [63:0] oDATA_DATA;
  logic [27:0] oDATA_MMU_FLAGS;

  logic        oMEM_REQ;
  logic        oMEM_SRC;
  logic [1:0]  oMEM_ORDER;
  logic [3:0]  oMEM_MASK;
  logic        oMEM_RW;
  logic [13:0] oMEM_TID;
  logic [1:0]  oMEM_MMUMOD;
  logic [31:0] oMEM_PDT;
  logic [31:0] oMEM_ADDR;
  logic [31:0] oMEM_DATA;
  logic        iMEM_LOCK;
  logic        iMEM_VALID;
  logic        iMEM_PAGEFAULT;
  logic [63:0] iMEM_DATA;
  logic [27:0] iMEM_MMU_FLAGS;
  logic        oPROTOCOL_ERROR;

  modport slave (
    input  iINST_REQ, iINST_MMUMOD, iINST_PDT, iINST_ADDR, iINST_DISCARD,
    output oINST_LOCK, oINST_VALID, oINST_PAGEFAULT, oINST_DATA, oINST_MMU_FLAGS,
    input  iDATA_REQ, iDATA_ORDER, iDATA_MASK, iDATA_RW, iDATA_TID,
           iDATA_MMUMOD, iDATA_PDT, iDATA_ADDR, iDATA_DATA,
    output oDATA_LOCK, oDATA_VALID, oDATA_PAGEFAULT, oDATA_DATA, oDATA_MMU_FLAGS,
    output oMEM_REQ, oMEM_SRC, oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_TID,
           oMEM_MMUMOD, oMEM_PDT, oMEM_ADDR, oMEM_DATA, oPROTOCOL_ERROR,
    input  iMEM_LOCK, iMEM_VALID, iMEM_PAGEFAULT, iMEM_DATA, iMEM_MMU_FLAGS
  );

  modport master (
    output iINST_REQ, iINST_MMUMOD, iINST_PDT, iINST_ADDR, iINST_DISCARD,
    input  oINST_LOCK, oINST_VALID, oINST_PAGEFAULT, oINST_DATA, oINST_MMU_FLAGS,
    output iDATA_REQ, iDATA_ORDER, iDATA_MASK, iDATA_RW, iDATA_TID,
           iDATA_MMUMOD, iDATA_PDT, iDATA_ADDR, iDATA_DATA,
    input  oDATA_LOCK, oDATA_VALID, oDATA_PAGEFAULT, oDATA_DATA, oDATA_MMU_FLAGS,
    input  oMEM_REQ, oMEM_SRC, oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_TID,
           oMEM_MMUMOD, oMEM_PDT, oMEM_ADDR, oMEM_DATA, oPROTOCOL_ERROR,
    output iMEM_LOCK, iMEM_VALID, iMEM_PAGEFAULT, iMEM_DATA, iMEM_MMU_FLAGS
  );

endinterface

// File: rtl/core_mem_arb_tag_fifo.sv
// Circular FIFO of {src, drop} tags for requests in flight, one-cycle update,
// with a bulk port that marks every fetch entry as dropped.
module core_mem_arb_tag_fifo
  import core_mem_arb_pkg::*;
#(
  parameter int P_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  tag_t             push_dat,
  input  logic             pop_vld,
  input  logic             mark_drop,
  output tag_t             head_dat,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

  tag_t [P_DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(P_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // marking stale slots too is harmless: they are overwritten on push
    if (mark_drop) begin
      for (int i = 0; i < P_DEPTH; i++) begin
        if (mem_q[i].src == SRC_INST) mem_d[i].drop = 1'b1;
      end
    end
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_vld) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_vld, pop_vld})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = cnt_q;
  assign empty    = (cnt_q == '0);

endmodule

// File: rtl/core_mem_arbiter.sv
// Merges fetch and data requests onto one in-order memory port (data priority,
// fetch starvation guard); request and response paths are each one registered cycle.
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int P_MAX_OUTSTANDING = 4,
  parameter int P_INST_STARVE     = 4
) (
  input logic               iCLOCK,
  input logic               iRESET_SYNC,
  core_mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(P_INST_STARVE + 1);

  logic             slot_free, can_grant, inst_elig, fetch_forced;
  logic             grant_inst, grant_data;
  mem_req_t         inst_pay, data_pay;
  logic             mem_req_q, mem_req_d;
  mem_req_t         mem_pay_q, mem_pay_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             inst_vld_q, inst_vld_d, data_vld_q, data_vld_d;
  mem_rsp_t         rsp_in, inst_rsp_q, inst_rsp_d, data_rsp_q, data_rsp_d;
  logic             proto_err_q, proto_err_d;
  tag_t             push_tag, head_tag;
  logic             push, pop, fifo_empty, rsp_drop;
  logic [CNT_W-1:0] fifo_cnt;

  core_mem_arb_tag_fifo #(.P_DEPTH(P_MAX_OUTSTANDING)) u_tag_fifo (
    .clk       (iCLOCK),
    .rst       (iRESET_SYNC),
    .push_vld  (push),
    .push_dat  (push_tag),
    .pop_vld   (pop),
    .mark_drop (bus.iINST_DISCARD),
    .head_dat  (head_tag),
    .count     (fifo_cnt),
    .empty     (fifo_empty)
  );

  always_comb begin
    slot_free    = !mem_req_q || !bus.iMEM_LOCK;
    // count is taken before this cycle's pop, so a full FIFO refuses even while draining
    can_grant    = !iRESET_SYNC && slot_free && (fifo_cnt < CNT_W'(P_MAX_OUTSTANDING));
    inst_elig    = bus.iINST_REQ && !bus.iINST_DISCARD;
    fetch_forced = (starve_q == SW'(P_INST_STARVE));
    grant_inst   = can_grant && inst_elig && (fetch_forced || !bus.iDATA_REQ);
    grant_data   = can_grant && bus.iDATA_REQ && !grant_inst;
  end

  always_comb begin
    inst_pay        = '0;
    inst_pay.src    = SRC_INST;
    inst_pay.order  = FETCH_ORDER;
    inst_pay.mask   = FETCH_MASK;
    inst_pay.rw     = 1'b1;
    inst_pay.mmumod = bus.iINST_MMUMOD;
    inst_pay.pdt    = bus.iINST_PDT;
    inst_pay.addr   = bus.iINST_ADDR;

    data_pay.src    = SRC_DATA;
    data_pay.order  = bus.iDATA_ORDER;
    data_pay.mask   = bus.iDATA_MASK;
    data_pay.rw     = bus.iDATA_RW;
    data_pay.tid    = bus.iDATA_TID;
    data_pay.mmumod = bus.iDATA_MMUMOD;
    data_pay.pdt    = bus.iDATA_PDT;
    data_pay.addr   = bus.iDATA_ADDR;
    data_pay.data   = bus.iDATA_DATA;
  end

  always_comb begin
    push          = grant_inst || grant_data;
    push_tag.src  = grant_data ? SRC_DATA : SRC_INST;
    push_tag.drop = 1'b0;

    mem_req_d = mem_req_q;
    mem_pay_d = mem_pay_q;
    if (push) begin
      mem_req_d = 1'b1;
      mem_pay_d = grant_inst ? inst_pay : data_pay;
    end else if (!bus.iMEM_LOCK) begin
      mem_req_d = 1'b0;
    end

    if (!bus.iINST_REQ || grant_inst) starve_d = '0;
    else if (grant_data && !fetch_forced) starve_d = starve_q + SW'(1);
    else starve_d = starve_q;

    rsp_in.pagefault = bus.iMEM_PAGEFAULT;
    rsp_in.mmu_flags = bus.iMEM_MMU_FLAGS;
    rsp_in.data      = bus.iMEM_DATA;

    pop         = bus.iMEM_VALID && !fifo_empty;
    // a discard landing on the same cycle as the fetch response still kills it
    rsp_drop    = head_tag.drop || (head_tag.src == SRC_INST && bus.iINST_DISCARD);
    inst_vld_d  = pop && (head_tag.src == SRC_INST) && !rsp_drop;
    data_vld_d  = pop && (head_tag.src == SRC_DATA) && !head_tag.drop;
    inst_rsp_d  = inst_vld_d ? rsp_in : inst_rsp_q;
    data_rsp_d  = data_vld_d ? rsp_in : data_rsp_q;
    proto_err_d = proto_err_q || (bus.iMEM_VALID && fifo_empty);
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      mem_req_q   <= 1'b0;
      mem_pay_q   <= '0;
      starve_q    <= '0;
      inst_vld_q  <= 1'b0;
      data_vld_q  <= 1'b0;
      inst_rsp_q  <= '0;
      data_rsp_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_pay_q   <= mem_pay_d;
      starve_q    <= starve_d;
      inst_vld_q  <= inst_vld_d;
      data_vld_q  <= data_vld_d;
      inst_rsp_q  <= inst_rsp_d;
      data_rsp_q  <= data_rsp_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.oINST_LOCK      = !grant_inst;
  assign bus.oDATA_LOCK      = !grant_data;

  assign bus.oMEM_REQ        = mem_req_q;
  assign bus.oMEM_SRC        = mem_pay_q.src;
  assign bus.oMEM_ORDER      = mem_pay_q.order;
  assign bus.oMEM_MASK       = mem_pay_q.mask;
  assign bus.oMEM_RW         = mem_pay_q.rw;
  assign bus.oMEM_TID        = mem_pay_q.tid;
  assign bus.oMEM_MMUMOD     = mem_pay_q.mmumod;
  assign bus.oMEM_PDT        = mem_pay_q.pdt;
  assign bus.oMEM_ADDR       = mem_pay_q.addr;
  assign bus.oMEM_DATA       = mem_pay_q.data;

  assign bus.oINST_VALID     = inst_vld_q;
  assign bus.oINST_PAGEFAULT = inst_rsp_q.pagefault;
  assign bus.oINST_MMU_FLAGS = inst_rsp_q.mmu_flags;
  assign bus.oINST_DATA      = inst_rsp_q.data;
  assign bus.oDATA_VALID     = data_vld_q;
  assign bus.oDATA_PAGEFAULT = data_rsp_q.pagefault;
  assign bus.oDATA_MMU_FLAGS = data_rsp_q.mmu_flags;
  assign bus.oDATA_DATA      = data_rsp_q.data;

  assign bus.oPROTOCOL_ERROR = proto_err_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a queue-based reference model.
module tb_core_mem_arbiter;

  localparam int MAXO   = 4;
  localparam int STARVE = 4;

  logic iCLOCK = 1'b0;
  logic iRESET_SYNC = 1'b1;

  core_mem_arbiter_if bus();

  core_mem_arbiter #(.P_MAX_OUTSTANDING(MAXO), .P_INST_STARVE(STARVE)) dut (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .bus         (bus)
  );

  always #5 iCLOCK = ~iCLOCK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit src;
    bit drop;
  } mtag_t;

  mtag_t        tq[$];
  bit           m_req = 0;
  logic [119:0] m_pay = '0;
  int           m_starve = 0;
  bit           e_iv = 0, e_dv = 0, e_err = 0;
  logic [92:0]  e_irsp = '0, e_drsp = '0;

  function automatic logic [119:0] dut_pay();
    return {bus.oMEM_SRC, bus.oMEM_ORDER, bus.oMEM_MASK, bus.oMEM_RW, bus.oMEM_TID,
            bus.oMEM_MMUMOD, bus.oMEM_PDT, bus.oMEM_ADDR, bus.oMEM_DATA};
  endfunction

  always @(negedge iCLOCK) begin : model
    bit    win_i, win_d;
    mtag_t t;
    chk("mem_req", bus.oMEM_REQ, m_req);
    if (m_req) chk("mem_payload", dut_pay(), m_pay);
    chk("inst_valid", bus.oINST_VALID, e_iv);
    if (e_iv) chk("inst_rsp", {bus.oINST_PAGEFAULT, bus.oINST_MMU_FLAGS, bus.oINST_DATA}, e_irsp);
    chk("data_valid", bus.oDATA_VALID, e_dv);
    if (e_dv) chk("data_rsp", {bus.oDATA_PAGEFAULT, bus.oDATA_MMU_FLAGS, bus.oDATA_DATA}, e_drsp);
    chk("proto_err", bus.oPROTOCOL_ERROR, e_err);

    // data wins unless absent or fetch has been starved long enough
    win_i = 0;
    win_d = 0;
    if (!iRESET_SYNC && (!m_req || !bus.iMEM_LOCK) && tq.size() < MAXO) begin
      if (bus.iINST_REQ && !bus.iINST_DISCARD && (m_starve == STARVE || !bus.iDATA_REQ))
        win_i = 1;
      else if (bus.iDATA_REQ)
        win_d = 1;
    end
    chk("inst_lock", bus.oINST_LOCK, !win_i);
    chk("data_lock", bus.oDATA_LOCK, !win_d);

    if (iRESET_SYNC) begin
      tq.delete();
      m_req = 0; m_pay = '0; m_starve = 0;
      e_iv = 0; e_dv = 0; e_err = 0; e_irsp = '0; e_drsp = '0;
    end else begin
      e_iv = 0;
      e_dv = 0;
      if (bus.iMEM_VALID) begin
        if (tq.size() == 0) e_err = 1;
        else begin
          t = tq.pop_front();
          if (t.src) begin
            e_dv   = !t.drop;
            e_drsp = {bus.iMEM_PAGEFAULT, bus.iMEM_MMU_FLAGS, bus.iMEM_DATA};
          end else if (!t.drop && !bus.iINST_DISCARD) begin
            e_iv   = 1;
            e_irsp = {bus.iMEM_PAGEFAULT, bus.iMEM_MMU_FLAGS, bus.iMEM_DATA};
          end
        end
      end
      if (bus.iINST_DISCARD) foreach (tq[k]) if (!tq[k].src) tq[k].drop = 1;
      if (win_i || win_d) begin
        tq.push_back('{src: win_d, drop: 1'b0});
        m_req = 1;
        if (win_i) m_pay = {1'b0, 2'b10, 4'hF, 1'b1, 14'd0, bus.iINST_MMUMOD,
                            bus.iINST_PDT, bus.iINST_ADDR, 32'd0};
        else       m_pay = {1'b1, bus.iDATA_ORDER, bus.iDATA_MASK, bus.iDATA_RW, bus.iDATA_TID,
                            bus.iDATA_MMUMOD, bus.iDATA_PDT, bus.iDATA_ADDR, bus.iDATA_DATA};
      end else if (!bus.iMEM_LOCK) m_req = 0;
      if (!bus.iINST_REQ || win_i) m_starve = 0;
      else if (win_d && m_starve < STARVE) m_starve++;
    end
  end

  // ---------------- stimulus helpers ----------------
  int mem_pend = 0;
  bit inst_acc, data_acc, mem_acc, s_ilock, s_dlock;

  task automatic tick();
    @(negedge iCLOCK);
    s_ilock  = bus.oINST_LOCK;
    s_dlock  = bus.oDATA_LOCK;
    inst_acc = bus.iINST_REQ && !bus.oINST_LOCK;
    data_acc = bus.iDATA_REQ && !bus.oDATA_LOCK;
    mem_acc  = bus.oMEM_REQ && !bus.iMEM_LOCK && !iRESET_SYNC;
    @(posedge iCLOCK);
    #1;
    if (inst_acc) bus.iINST_REQ = 0;
    if (data_acc) bus.iDATA_REQ = 0;
    if (mem_acc) mem_pend++;
    bus.iMEM_VALID    = 0;
    bus.iINST_DISCARD = 0;
  endtask

  task automatic raise_inst(input logic [31:0] addr);
    bus.iINST_REQ    = 1;
    bus.iINST_ADDR   = addr;
    bus.iINST_PDT    = $urandom;
    bus.iINST_MMUMOD = 2'($urandom);
  endtask

  task automatic raise_data();
    bus.iDATA_REQ    = 1;
    bus.iDATA_ORDER  = 2'($urandom);
    bus.iDATA_MASK   = 4'($urandom);
    bus.iDATA_RW     = 1'($urandom);
    bus.iDATA_TID    = 14'($urandom);
    bus.iDATA_MMUMOD = 2'($urandom);
    bus.iDATA_PDT    = $urandom;
    bus.iDATA_ADDR   = $urandom;
    bus.iDATA_DATA   = $urandom;
  endtask

  task automatic respond(input logic [63:0] d);
    bus.iMEM_VALID     = 1;
    bus.iMEM_DATA      = d;
    bus.iMEM_PAGEFAULT = 1'($urandom);
    bus.iMEM_MMU_FLAGS = 28'($urandom);
    if (mem_pend > 0) mem_pend--;
  endtask

  task automatic do_reset();
    iRESET_SYNC       = 1;
    bus.iINST_REQ     = 0;
    bus.iDATA_REQ     = 0;
    bus.iMEM_LOCK     = 0;
    bus.iMEM_VALID    = 0;
    bus.iINST_DISCARD = 0;
    tick();
    tick();
    chk("reset_inst_lock", s_ilock, 1);
    chk("reset_data_lock", s_dlock, 1);
    iRESET_SYNC = 0;
    mem_pend    = 0;
  endtask

  // ---------------- scenarios ----------------
  initial begin : main
    string        exp_seq;
    byte          got;
    int           n_i, n_d;
    logic [119:0] held;

    bus.iINST_REQ = 0; bus.iINST_MMUMOD = 0; bus.iINST_PDT = 0; bus.iINST_ADDR = 0;
    bus.iINST_DISCARD = 0;
    bus.iDATA_REQ = 0; bus.iDATA_ORDER = 0; bus.iDATA_MASK = 0; bus.iDATA_RW = 0;
    bus.iDATA_TID = 0; bus.iDATA_MMUMOD = 0; bus.iDATA_PDT = 0; bus.iDATA_ADDR = 0;
    bus.iDATA_DATA = 0;
    bus.iMEM_LOCK = 0; bus.iMEM_VALID = 0; bus.iMEM_PAGEFAULT = 0; bus.iMEM_DATA = 0;
    bus.iMEM_MMU_FLAGS = 0;

    do_reset();
    chk("rst_mem_req", bus.oMEM_REQ, 0);
    chk("rst_valids_err", {bus.oINST_VALID, bus.oDATA_VALID, bus.oPROTOCOL_ERROR}, 0);

    // single fetch, response three cycles after acceptance
    raise_inst(32'h100);
    tick();
    chk("fetch_accept_lock", s_ilock, 0);
    chk("fetch_mem_req", bus.oMEM_REQ, 1);
    chk("fetch_src", bus.oMEM_SRC, 0);
    chk("fetch_order", bus.oMEM_ORDER, 2'b10);
    chk("fetch_mask", bus.oMEM_MASK, 4'hF);
    chk("fetch_rw", bus.oMEM_RW, 1);
    chk("fetch_addr", bus.oMEM_ADDR, 32'h100);
    tick();
    tick();
    respond(64'h1122334455667788);
    tick();
    chk("fetch_rsp_valid", bus.oINST_VALID, 1);
    chk("fetch_rsp_data", bus.oINST_DATA, 64'h1122334455667788);
    chk("fetch_no_data_valid", bus.oDATA_VALID, 0);
    tick();
    chk("fetch_rsp_one_cycle", bus.oINST_VALID, 0);

    // both requesters saturated: four data wins then a forced fetch
    do_reset();
    exp_seq = "DDDDIDDDDI";
    raise_inst($urandom);
    raise_data();
    for (int i = 0; i < 10; i++) begin
      if (mem_pend > 0) respond({$urandom, $urandom});
      tick();
      got = !s_dlock ? "D" : (!s_ilock ? "I" : "-");
      chk($sformatf("starve_seq_%0d", i), got, exp_seq[i]);
      if (!bus.iINST_REQ) raise_inst($urandom);
      if (!bus.iDATA_REQ) raise_data();
    end

    // outstanding limit: fifth request waits for a response plus one cycle
    do_reset();
    raise_data();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("fill_accept_%0d", i), s_dlock, 0);
      raise_data();
    end
    tick();
    chk("full_lock", s_dlock, 1);
    respond({$urandom, $urandom});
    tick();
    chk("full_pop_lock", s_dlock, 1);
    tick();
    chk("refill_accept", s_dlock, 0);

    // discard after I0, D0, I1: only D0 comes back
    do_reset();
    raise_inst(32'h200);
    tick();
    chk("disc_i0_accept", s_ilock, 0);
    raise_data();
    tick();
    chk("disc_d0_accept", s_dlock, 0);
    raise_inst(32'h204);
    tick();
    chk("disc_i1_accept", s_ilock, 0);
    bus.iINST_DISCARD = 1;
    tick();
    n_i = 0;
    n_d = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_pend > 0) respond({$urandom, $urandom});
      tick();
      n_i += int'(bus.oINST_VALID);
      n_d += int'(bus.oDATA_VALID);
    end
    chk("discard_inst_count", n_i, 0);
    chk("discard_data_count", n_d, 1);

    // downstream stall holds the slot and locks both requesters
    do_reset();
    bus.iMEM_LOCK = 1;
    raise_data();
    tick();
    chk("stall_first_accept", s_dlock, 0);
    raise_data();
    raise_inst($urandom);
    held = dut_pay();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_mem_req", bus.oMEM_REQ, 1);
      chk("stall_payload", dut_pay(), held);
      chk("stall_locks", {s_ilock, s_dlock}, 2'b11);
    end
    bus.iMEM_LOCK = 0;
    tick();
    chk("release_data_accept", s_dlock, 0);
    tick();
    chk("release_inst_accept", s_ilock, 0);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!bus.iINST_REQ && $urandom_range(2) == 0) raise_inst($urandom);
      if (!bus.iDATA_REQ && $urandom_range(2) == 0) raise_data();
      bus.iMEM_LOCK = ($urandom_range(3) == 0);
      if (mem_pend > 0 && $urandom_range(1) == 0) respond({$urandom, $urandom});
      bus.iINST_DISCARD = ($urandom_range(15) == 0);
      tick();
    end

    // response with nothing outstanding after a mid-traffic reset
    do_reset();
    respond({$urandom, $urandom});
    tick();
    chk("proto_err_set", bus.oPROTOCOL_ERROR, 1);
    chk("proto_no_forward", {bus.oINST_VALID, bus.oDATA_VALID}, 2'b00);
    tick();
    tick();
    chk("proto_err_sticky", bus.oPROTOCOL_ERROR, 1);
    do_reset();
    chk("proto_err_cleared", bus.oPROTOCOL_ERROR, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
